// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that lends one external combinational ALU to NUM_REQ
// requesters. Each operation takes one grant cycle, one ALU settle cycle and
// a response cycle that is held until the granted requester accepts it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; grants the next one round-robin
// EXEC  | operands registered, ALU settling; result captured on exit
// RESP  | registered result offered to the granted requester until taken
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_srca,
  input  logic [NUM_REQ*32-1:0]   req_srcb,
  input  logic [NUM_REQ*5-1:0]    req_ctrl,
  input  logic [NUM_REQ*3-1:0]    req_funct3,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [31:0]             resp_result,
  output logic                    resp_zero,
  output logic                    resp_carry,
  output logic [31:0]             alu_srca,
  output logic [31:0]             alu_srcb,
  output logic [4:0]              alu_ctrl,
  output logic [2:0]              alu_funct3,
  input  logic [31:0]             alu_result,
  input  logic                    alu_zero,
  input  logic                    alu_carry,
  output logic                    busy,
  output logic [PTR_W-1:0]        grant_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [31:0]        srca_q, srca_d;
  logic [31:0]        srcb_q, srcb_d;
  logic [4:0]         ctrl_q, ctrl_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [31:0]        result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;

  logic               arb_found;
  logic [PTR_W-1:0]   arb_idx;
  logic [31:0]        sel_srca;
  logic [31:0]        sel_srcb;
  logic [4:0]         sel_ctrl;
  logic [2:0]         sel_funct3;
  logic               resp_hs;

  // Round-robin pick: the valid requester at the smallest wrap-around
  // distance from rr_ptr wins.
  always_comb begin
    int best_d;
    arb_found = 1'b0;
    arb_idx   = '0;
    best_d    = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      int d;
      d = (i + NUM_REQ - int'(rr_ptr_q)) % NUM_REQ;
      if (req_valid[i] && (d < best_d)) begin
        best_d    = d;
        arb_idx   = PTR_W'(i);
        arb_found = 1'b1;
      end
    end
  end

  // Operand mux for the candidate requester.
  always_comb begin
    sel_srca   = '0;
    sel_srcb   = '0;
    sel_ctrl   = '0;
    sel_funct3 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == PTR_W'(i)) begin
        sel_srca   = req_srca[32*i +: 32];
        sel_srcb   = req_srcb[32*i +: 32];
        sel_ctrl   = req_ctrl[5*i +: 5];
        sel_funct3 = req_funct3[3*i +: 3];
      end
    end
  end

  // Handshake outputs; only the granted requester's resp_ready matters.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_hs    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state_q == S_IDLE) && !flush && arb_found && (arb_idx == PTR_W'(i)))
        req_ready[i] = 1'b1;
      if ((state_q == S_RESP) && (grant_q == PTR_W'(i))) begin
        resp_valid[i] = 1'b1;
        resp_hs       = resp_ready[i];
      end
    end
  end

  // Next-state logic: grant, capture and release.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    srca_d   = srca_q;
    srcb_d   = srcb_q;
    ctrl_d   = ctrl_q;
    funct3_d = funct3_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    case (state_q)
      S_IDLE: begin
        if (!flush && arb_found) begin
          srca_d   = sel_srca;
          srcb_d   = sel_srcb;
          ctrl_d   = sel_ctrl;
          funct3_d = sel_funct3;
          grant_d  = arb_idx;
          rr_ptr_d = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = alu_result;
          zero_d   = alu_zero;
          carry_d  = alu_carry;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        // A handshake in the same cycle as flush still counts as delivered.
        if (resp_hs || flush)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      ctrl_q   <= '0;
      funct3_q <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      ctrl_q   <= ctrl_d;
      funct3_q <= funct3_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  assign alu_srca    = srca_q;
  assign alu_srcb    = srcb_q;
  assign alu_ctrl    = ctrl_q;
  assign alu_funct3  = funct3_q;
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_carry  = carry_q;
  assign busy        = (state_q != S_IDLE);
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU stands in for the shared
// unit, and expected grants/results come from a round-robin list model.
module tb_alu_share_arbiter;

  localparam int N = 2;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_srca;
  logic [N*32-1:0]   req_srcb;
  logic [N*5-1:0]    req_ctrl;
  logic [N*3-1:0]    req_funct3;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready;
  logic [31:0]       resp_result;
  logic              resp_zero;
  logic              resp_carry;
  logic [31:0]       alu_srca;
  logic [31:0]       alu_srcb;
  logic [4:0]        alu_ctrl;
  logic [2:0]        alu_funct3;
  logic [31:0]       alu_result;
  logic              alu_zero;
  logic              alu_carry;
  logic              busy;
  logic [0:0]        grant_id;

  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  logic [4:0]  op_c [N];
  logic [2:0]  op_f [N];

  int n_err = 0;
  int n_chk = 0;
  int mptr  = 0;

  alu_share_arbiter #(.NUM_REQ(N), .PTR_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_srca(req_srca), .req_srcb(req_srcb),
    .req_ctrl(req_ctrl), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_carry(resp_carry),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .alu_ctrl(alu_ctrl), .alu_funct3(alu_funct3),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .busy(busy), .grant_id(grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_srca[32*i +: 32] = op_a[i];
      req_srcb[32*i +: 32] = op_b[i];
      req_ctrl[5*i +: 5]   = op_c[i];
      req_funct3[3*i +: 3] = op_f[i];
    end
  end

  // {zero, carry, result}: 0 add, 1 sub, 2 and, 3 or, 4 xor.
  // zero is the branch-taken flag selected by funct3.
  function automatic logic [33:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] c, input logic [2:0] f);
    logic [32:0] s;
    logic [31:0] r;
    logic        cy;
    logic        z;
    s  = {1'b0, a} + {1'b0, b};
    r  = 32'h0;
    cy = 1'b0;
    case (c)
      5'd0: begin r = s[31:0]; cy = s[32]; end
      5'd1: r = a - b;
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      default: r = 32'h0;
    endcase
    case (f)
      3'b000:  z = (a == b);
      3'b001:  z = (a != b);
      3'b100:  z = ($signed(a) < $signed(b));
      3'b101:  z = ($signed(a) >= $signed(b));
      3'b110:  z = (a < b);
      3'b111:  z = (a >= b);
      default: z = 1'b0;
    endcase
    return {z, cy, r};
  endfunction

  assign {alu_zero, alu_carry, alu_result} = alu_model(alu_srca, alu_srcb, alu_ctrl, alu_funct3);

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // First valid requester scanning upward from p with wrap-around.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] oh;
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
    return oh;
  endfunction

  // One full operation, entered just after a negedge with inputs driven.
  // Returns just after the negedge following the response handshake.
  task automatic serve(input int stall, input bit hold,
                       output logic [31:0] r, output logic z, output logic c, output int g);
    logic [33:0]  e;
    logic [31:0]  ea;
    logic [N-1:0] oh;
    g  = pick(req_valid, mptr);
    oh = onehot(g);
    if (g < 0) begin
      check("serve_no_request", 64'(req_valid), 64'h1);
      r = 32'h0; z = 1'b0; c = 1'b0;
      return;
    end
    e  = alu_model(op_a[g], op_b[g], op_c[g], op_f[g]);
    ea = op_a[g];
    #1;
    check("req_ready_grant", 64'(req_ready), 64'(oh));
    check("busy_idle", 64'(busy), 64'h0);
    mptr = (g + 1) % N;
    @(negedge clk);
    if (!hold) req_valid = '0;
    op_a[g] = ~op_a[g];
    #1;
    check("exec_req_ready", 64'(req_ready), 64'h0);
    check("exec_resp_valid", 64'(resp_valid), 64'h0);
    check("exec_alu_srca", 64'(alu_srca), 64'(ea));
    @(negedge clk);
    for (int s = 0; s < stall; s++) begin
      resp_ready = ~oh;
      #1;
      check("stall_resp_valid", 64'(resp_valid), 64'(oh));
      check("stall_result", 64'(resp_result), 64'(e[31:0]));
      check("stall_req_ready", 64'(req_ready), 64'h0);
      @(negedge clk);
    end
    resp_ready = oh;
    #1;
    check("resp_valid", 64'(resp_valid), 64'(oh));
    check("resp_result", 64'(resp_result), 64'(e[31:0]));
    check("resp_zero", 64'(resp_zero), 64'(e[33]));
    check("resp_carry", 64'(resp_carry), 64'(e[32]));
    check("grant_id", 64'(grant_id), 64'(g));
    r = resp_result;
    z = resp_zero;
    c = resp_carry;
    @(negedge clk);
    resp_ready = '0;
    #1;
    check("idle_after_accept", 64'(busy), 64'h0);
    check("no_resp_after_accept", 64'(resp_valid), 64'h0);
  endtask

  // req_ready and resp_valid must never be active together.
  always @(negedge clk) begin
    #3;
    check("ready_valid_exclusive", 64'((|req_ready) && (|resp_valid)), 64'h0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          rq;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  c;
    logic [2:0]  f;
    logic [31:0] er;
    logic        ez;
    logic        ec;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [31:0] r;
    logic        z;
    logic        c;
    int          g;

    tbl[0] = '{0, 32'd5,        32'd3,        5'd1, 3'b010, 32'd2,         1'b0, 1'b0};
    tbl[1] = '{1, 32'hA5,       32'hA5,       5'd1, 3'b000, 32'h0,         1'b1, 1'b0};
    tbl[2] = '{0, 32'hFFFF_FFFF, 32'd1,       5'd0, 3'b010, 32'h0,         1'b0, 1'b1};
    tbl[3] = '{1, 32'hF0F0,     32'h0FF0,     5'd2, 3'b011, 32'h00F0,      1'b0, 1'b0};
    tbl[4] = '{0, 32'hF0F0,     32'h0FF0,     5'd3, 3'b001, 32'hFFF0,      1'b1, 1'b0};
    tbl[5] = '{1, 32'hF0F0,     32'h0FF0,     5'd4, 3'b000, 32'hFF00,      1'b0, 1'b0};
    tbl[6] = '{0, 32'd1,        32'd3,        5'd1, 3'b111, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[7] = '{1, 32'hFFFF_FFFF, 32'd1,       5'd1, 3'b100, 32'hFFFF_FFFE, 1'b1, 1'b0};
    tbl[8] = '{0, 32'hFFFF_FFFF, 32'd1,       5'd1, 3'b110, 32'hFFFF_FFFE, 1'b0, 1'b0};

    rst_n = 1'b0; flush = 1'b0; req_valid = '0; resp_ready = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_c[i] = '0; op_f[i] = '0;
    end
    #12;
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_grant_id", 64'(grant_id), 64'h0);
    check("rst_resp_result", 64'(resp_result), 64'h0);
    check("rst_alu_srca", 64'(alu_srca), 64'h0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
    #1;

    // Contention from rr_ptr=0: grants alternate 0,1,0,1.
    op_a[0] = 32'd10; op_b[0] = 32'd4; op_c[0] = 5'd1; op_f[0] = 3'b010;
    op_a[1] = 32'd20; op_b[1] = 32'd5; op_c[1] = 5'd0; op_f[1] = 3'b010;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      op_a[0] = 32'd10; op_a[1] = 32'd20;
      serve(0, (k != 3), r, z, c, g);
      check("contention_order", 64'(g), 64'(k % 2));
      check("contention_result", 64'(r), (k % 2 == 0) ? 64'd6 : 64'd25);
    end
    req_valid = '0;

    // Table of single requests with hand-computed results.
    for (int t = 0; t < 9; t++) begin
      op_a[tbl[t].rq] = tbl[t].a;
      op_b[tbl[t].rq] = tbl[t].b;
      op_c[tbl[t].rq] = tbl[t].c;
      op_f[tbl[t].rq] = tbl[t].f;
      req_valid = onehot(tbl[t].rq);
      serve(0, 1'b0, r, z, c, g);
      check("tbl_result", 64'(r), 64'(tbl[t].er));
      check("tbl_zero", 64'(z), 64'(tbl[t].ez));
      check("tbl_carry", 64'(c), 64'(tbl[t].ec));
    end

    // Backpressure: result 0xFFFF_FFFE held for 5 stalled cycles.
    op_a[1] = 32'd1; op_b[1] = 32'd3; op_c[1] = 5'd1; op_f[1] = 3'b010;
    req_valid = 2'b10;
    serve(5, 1'b0, r, z, c, g);
    check("bp_result", 64'(r), 64'hFFFF_FFFE);

    // Flush in EXEC: no response, next request served normally.
    op_a[0] = 32'd7; op_b[0] = 32'd8; op_c[0] = 5'd0; op_f[0] = 3'b010;
    req_valid = 2'b01;
    g = pick(req_valid, mptr);
    #1;
    check("fx_req_ready", 64'(req_ready), 64'(onehot(g)));
    mptr = (g + 1) % N;
    @(negedge clk);
    req_valid = '0; flush = 1'b1;
    #1;
    check("fx_busy_exec", 64'(busy), 64'h1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fx_busy_after", 64'(busy), 64'h0);
    check("fx_no_resp", 64'(resp_valid), 64'h0);
    @(negedge clk);
    #1;
    check("fx_no_resp_late", 64'(resp_valid), 64'h0);
    op_a[0] = 32'd2; op_b[0] = 32'd2;
    req_valid = 2'b01;
    serve(0, 1'b0, r, z, c, g);
    check("fx_next_result", 64'(r), 64'd4);

    // Flush in IDLE blocks the grant and leaves rr_ptr alone.
    req_valid = 2'b11; flush = 1'b1;
    #1;
    check("fi_req_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fi_busy", 64'(busy), 64'h0);
    serve(0, 1'b0, r, z, c, g);
    check("fi_grant_after", 64'(g), 64'd1);

    // Flush in RESP drops the response.
    req_valid = 2'b01;
    g = pick(req_valid, mptr);
    mptr = (g + 1) % N;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    check("fr_resp_valid", 64'(resp_valid), 64'(onehot(g)));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fr_resp_gone", 64'(resp_valid), 64'h0);
    check("fr_busy", 64'(busy), 64'h0);

    // Async reset while in RESP, then req1 alone granted at once.
    op_a[1] = 32'h55; op_b[1] = 32'h11; op_c[1] = 5'd0;
    req_valid = 2'b10;
    g = pick(req_valid, mptr);
    mptr = (g + 1) % N;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    check("ar_resp_valid", 64'(resp_valid), 64'b10);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_resp_valid_rst", 64'(resp_valid), 64'h0);
    check("ar_busy_rst", 64'(busy), 64'h0);
    check("ar_grant_rst", 64'(grant_id), 64'h0);
    check("ar_result_rst", 64'(resp_result), 64'h0);
    check("ar_alu_srca_rst", 64'(alu_srca), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
    req_valid = 2'b10;
    serve(0, 1'b0, r, z, c, g);
    check("ar_regrant", 64'(g), 64'd1);
    check("ar_result", 64'(r), 64'h66);

    // Randomized traffic against the list model.
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++) begin
        op_a[i] = $urandom;
        op_b[i] = ($urandom_range(0, 3) == 0) ? op_a[i] : $urandom;
        op_c[i] = 5'($urandom_range(0, 4));
        op_f[i] = 3'($urandom_range(0, 7));
      end
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      serve($urandom_range(0, 3), 1'($urandom_range(0, 1)), r, z, c, g);
    end
    req_valid = '0;
    @(negedge clk);
    #4;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
